// File: rtl/addr_window_pkg.sv
// ---------------------------------------------------------------------------
// addr_window_pkg
// Shared definitions for the SNES address window mapper:
//   - cfg_field encodings used by the shadow-register write port
//   - bit positions of the per-window flags inside cfg_data (field 3)
//   - commit FSM state type
// ---------------------------------------------------------------------------
package addr_window_pkg;

   // cfg_field selects which shadow field a cfg_we write targets
   localparam logic [1:0] FIELD_MATCH       = 2'd0;
   localparam logic [1:0] FIELD_MASK        = 2'd1;
   localparam logic [1:0] FIELD_OFFSET      = 2'd2;
   localparam logic [1:0] FIELD_AMASK_FLAGS = 2'd3;

   // Flag bits carried alongside amask[23:0] when cfg_field = FIELD_AMASK_FLAGS
   localparam int FLAG_EN_BIT       = 24;
   localparam int FLAG_SAVERAM_BIT  = 25;
   localparam int FLAG_WRITABLE_BIT = 26;

   // Commit FSM: PEND means a shadow->active copy is waiting for an idle bus
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } commit_state_t;

endpackage

// File: rtl/addr_window_entry.sv
// ---------------------------------------------------------------------------
// addr_window_entry
// One programmable address window: shadow registers (written by the config
// port), active registers (loaded from shadow on i_copy) and the hit
// comparator working on the active copy.
//
// Ports:
//   CLK, RST      clock, synchronous active-high reset (clears everything)
//   i_wr_en       write the shadow field selected by i_field this edge
//   i_field       field select (match / mask / offset / amask+flags)
//   i_data        write data: [23:0] value, [26:24] flags for amask field
//   i_copy        copy every shadow field into the active copy this edge
//   i_addr        SNES address to compare
//   o_hit         active enable and address matches under mask
//   o_offset      active offset
//   o_amask       active address mask
//   o_saveram     active saveram flag
//   o_writable    active writable flag
// ---------------------------------------------------------------------------
module addr_window_entry
   import addr_window_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        i_wr_en,
   input  logic [1:0]  i_field,
   input  logic [26:0] i_data,
   input  logic        i_copy,
   input  logic [23:0] i_addr,
   output logic        o_hit,
   output logic [23:0] o_offset,
   output logic [23:0] o_amask,
   output logic        o_saveram,
   output logic        o_writable
);

   logic [23:0] r_sh_match, r_sh_mask, r_sh_offset, r_sh_amask;
   logic        r_sh_en, r_sh_saveram, r_sh_writable;
   logic [23:0] r_ac_match, r_ac_mask, r_ac_offset, r_ac_amask;
   logic        r_ac_en, r_ac_saveram, r_ac_writable;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sh_match    <= '0;
         r_sh_mask     <= '0;
         r_sh_offset   <= '0;
         r_sh_amask    <= '0;
         r_sh_en       <= 1'b0;
         r_sh_saveram  <= 1'b0;
         r_sh_writable <= 1'b0;
         r_ac_match    <= '0;
         r_ac_mask     <= '0;
         r_ac_offset   <= '0;
         r_ac_amask    <= '0;
         r_ac_en       <= 1'b0;
         r_ac_saveram  <= 1'b0;
         r_ac_writable <= 1'b0;
      end else begin
         if (i_wr_en) begin
            case (i_field)
               FIELD_MATCH:  r_sh_match  <= i_data[23:0];
               FIELD_MASK:   r_sh_mask   <= i_data[23:0];
               FIELD_OFFSET: r_sh_offset <= i_data[23:0];
               default: begin
                  r_sh_amask    <= i_data[23:0];
                  r_sh_en       <= i_data[FLAG_EN_BIT];
                  r_sh_saveram  <= i_data[FLAG_SAVERAM_BIT];
                  r_sh_writable <= i_data[FLAG_WRITABLE_BIT];
               end
            endcase
         end
         // Writes are blocked by the parent while a copy can happen, so the
         // copy always sees a stable shadow value.
         if (i_copy) begin
            r_ac_match    <= r_sh_match;
            r_ac_mask     <= r_sh_mask;
            r_ac_offset   <= r_sh_offset;
            r_ac_amask    <= r_sh_amask;
            r_ac_en       <= r_sh_en;
            r_ac_saveram  <= r_sh_saveram;
            r_ac_writable <= r_sh_writable;
         end
      end
   end

   assign o_hit      = r_ac_en && (((i_addr ^ r_ac_match) & r_ac_mask) == 24'd0);
   assign o_offset   = r_ac_offset;
   assign o_amask    = r_ac_amask;
   assign o_saveram  = r_ac_saveram;
   assign o_writable = r_ac_writable;

endmodule

// File: rtl/addr_window_map.sv
// ---------------------------------------------------------------------------
// addr_window_map
// Translates SNES bus addresses through NWIN programmable windows. The
// configuration port writes a shadow table; a commit copies the whole shadow
// table to the active table atomically once the SNES bus is idle.
// Translation is a 2-stage pipeline: stage 1 registers the priority-selected
// window (lowest index wins), stage 2 registers the translated address.
//
// Handshake: SNES_ADDR_VALID marks a request in the cycle it is presented;
// there is no back-pressure, one request per cycle is accepted, and out_valid
// rises exactly 2 cycles later for that request. When out_valid=0 or there
// was no hit, every result output is 0.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   SNES_ADDR[23:0]   address to translate, SNES_ADDR_VALID qualifies it
//   SNES_BUS_IDLE     active table may be updated this cycle
//   cfg_we/cfg_win/cfg_field/cfg_data   shadow write port (ignored when busy)
//   cfg_commit        request shadow->active copy
//   cfg_busy          a commit is pending
//   ROM_ADDR, ROM_HIT, IS_SAVERAM, IS_WRITABLE, WIN_IDX, out_valid  results
//   o_dbg_state       commit FSM state (1 = pending)
// ---------------------------------------------------------------------------
module addr_window_map
   import addr_window_pkg::*;
#(
   parameter int NWIN = 8,
   parameter int IW   = 3
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [23:0]   SNES_ADDR,
   input  logic          SNES_ADDR_VALID,
   input  logic          SNES_BUS_IDLE,
   input  logic          cfg_we,
   input  logic [IW-1:0] cfg_win,
   input  logic [1:0]    cfg_field,
   input  logic [31:0]   cfg_data,
   input  logic          cfg_commit,
   output logic          cfg_busy,
   output logic [23:0]   ROM_ADDR,
   output logic          ROM_HIT,
   output logic          IS_SAVERAM,
   output logic          IS_WRITABLE,
   output logic          out_valid,
   output logic [IW-1:0] WIN_IDX,
   output logic          o_dbg_state
);

   commit_state_t r_state, w_state_next;
   logic          w_copy, w_wr_ok;
   logic          w_unused;

   logic          w_hit      [NWIN];
   logic [23:0]   w_offset   [NWIN];
   logic [23:0]   w_amask    [NWIN];
   logic          w_saveram  [NWIN];
   logic          w_writable [NWIN];

   logic          w_any_hit;
   logic [IW-1:0] w_sel_idx;
   logic [23:0]   w_sel_offset, w_sel_amask;
   logic          w_sel_saveram, w_sel_writable;

   logic          r_s1_valid, r_s1_hit, r_s1_saveram, r_s1_writable;
   logic [IW-1:0] r_s1_idx;
   logic [23:0]   r_s1_addr, r_s1_offset, r_s1_amask;
   logic [23:0]   w_rom_sum;

   // cfg_data[31:27] carry nothing
   assign w_unused = ^cfg_data[31:27];

   // ---------------- commit FSM ----------------
   always_ff @(posedge CLK) begin
      if (RST) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_copy       = 1'b0;
      case (r_state)
         ST_IDLE: if (cfg_commit) w_state_next = ST_PEND;
         ST_PEND: if (SNES_BUS_IDLE) begin
            w_copy       = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign cfg_busy    = (r_state == ST_PEND);
   assign o_dbg_state = (r_state == ST_PEND);
   // A write in the same cycle as cfg_commit lands in shadow before the copy,
   // because the copy can only happen on a later edge (from PEND).
   assign w_wr_ok     = cfg_we && !cfg_busy;

   // ---------------- window table ----------------
   for (genvar g = 0; g < NWIN; g++) begin : g_win
      addr_window_entry u_entry (
         .CLK        (CLK),
         .RST        (RST),
         .i_wr_en    (w_wr_ok && (cfg_win == IW'(g))),
         .i_field    (cfg_field),
         .i_data     (cfg_data[26:0]),
         .i_copy     (w_copy),
         .i_addr     (SNES_ADDR),
         .o_hit      (w_hit[g]),
         .o_offset   (w_offset[g]),
         .o_amask    (w_amask[g]),
         .o_saveram  (w_saveram[g]),
         .o_writable (w_writable[g])
      );
   end

   // Scan from the top down so the lowest hitting index is the last written.
   always_comb begin
      w_any_hit      = 1'b0;
      w_sel_idx      = '0;
      w_sel_offset   = '0;
      w_sel_amask    = '0;
      w_sel_saveram  = 1'b0;
      w_sel_writable = 1'b0;
      for (int i = NWIN - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_any_hit      = 1'b1;
            w_sel_idx      = IW'(i);
            w_sel_offset   = w_offset[i];
            w_sel_amask    = w_amask[i];
            w_sel_saveram  = w_saveram[i];
            w_sel_writable = w_writable[i];
         end
      end
   end

   // ---------------- pipeline ----------------
   // Stage 1 samples the active table at the same edge a commit may land on,
   // so it always captures the pre-commit values for that request.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_s1_valid    <= 1'b0;
         r_s1_hit      <= 1'b0;
         r_s1_idx      <= '0;
         r_s1_addr     <= '0;
         r_s1_offset   <= '0;
         r_s1_amask    <= '0;
         r_s1_saveram  <= 1'b0;
         r_s1_writable <= 1'b0;
      end else begin
         r_s1_valid    <= SNES_ADDR_VALID;
         r_s1_hit      <= SNES_ADDR_VALID && w_any_hit;
         r_s1_idx      <= w_sel_idx;
         r_s1_addr     <= SNES_ADDR;
         r_s1_offset   <= w_sel_offset;
         r_s1_amask    <= w_sel_amask;
         r_s1_saveram  <= w_sel_saveram;
         r_s1_writable <= w_sel_writable;
      end
   end

   // 24-bit sum wraps modulo 2^24 by width
   assign w_rom_sum = r_s1_offset + (r_s1_addr & r_s1_amask);

   always_ff @(posedge CLK) begin
      if (RST) begin
         out_valid   <= 1'b0;
         ROM_HIT     <= 1'b0;
         ROM_ADDR    <= '0;
         WIN_IDX     <= '0;
         IS_SAVERAM  <= 1'b0;
         IS_WRITABLE <= 1'b0;
      end else begin
         out_valid   <= r_s1_valid;
         ROM_HIT     <= r_s1_hit;
         ROM_ADDR    <= r_s1_hit ? w_rom_sum : 24'd0;
         WIN_IDX     <= r_s1_hit ? r_s1_idx : '0;
         IS_SAVERAM  <= r_s1_hit && r_s1_saveram;
         IS_WRITABLE <= r_s1_hit && (r_s1_saveram || r_s1_writable);
      end
   end

endmodule

// File: tb/tb_addr_window_map.sv
module tb_addr_window_map;

   localparam int NWIN = 8;
   localparam int IW   = 3;

   // ---------------- clock / reset ----------------
   logic          CLK = 1'b0;
   logic          RST;
   logic [23:0]   SNES_ADDR;
   logic          SNES_ADDR_VALID, SNES_BUS_IDLE;
   logic          cfg_we, cfg_commit;
   logic [IW-1:0] cfg_win;
   logic [1:0]    cfg_field;
   logic [31:0]   cfg_data;
   logic          cfg_busy, ROM_HIT, IS_SAVERAM, IS_WRITABLE, out_valid, o_dbg_state;
   logic [23:0]   ROM_ADDR;
   logic [IW-1:0] WIN_IDX;

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   addr_window_map #(.NWIN(NWIN), .IW(IW)) dut (
      .CLK(CLK), .RST(RST), .SNES_ADDR(SNES_ADDR), .SNES_ADDR_VALID(SNES_ADDR_VALID),
      .SNES_BUS_IDLE(SNES_BUS_IDLE), .cfg_we(cfg_we), .cfg_win(cfg_win),
      .cfg_field(cfg_field), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
      .cfg_busy(cfg_busy), .ROM_ADDR(ROM_ADDR), .ROM_HIT(ROM_HIT),
      .IS_SAVERAM(IS_SAVERAM), .IS_WRITABLE(IS_WRITABLE), .out_valid(out_valid),
      .WIN_IDX(WIN_IDX), .o_dbg_state(o_dbg_state)
   );

   // ---------------- reference model ----------------
   typedef struct packed {
      logic          hit;
      logic [IW-1:0] idx;
      logic [23:0]   rom;
      logic          sv;
      logic          wr;
   } exp_t;

   logic [23:0] sh_match [NWIN], sh_mask [NWIN], sh_off [NWIN], sh_amask [NWIN];
   logic        sh_en [NWIN], sh_sv [NWIN], sh_wr [NWIN];
   logic [23:0] ac_match [NWIN], ac_mask [NWIN], ac_off [NWIN], ac_amask [NWIN];
   logic        ac_en [NWIN], ac_sv [NWIN], ac_wr [NWIN];
   logic        m_pend;

   exp_t exp_q[$];
   int   cyc_q[$];
   int   checks = 0;
   int   errors = 0;

   logic t_has_exp;
   exp_t t_exp;

   function automatic exp_t model_calc(logic [23:0] a);
      exp_t e = '0;
      for (int i = 0; i < NWIN; i++) begin
         if (ac_en[i] && ((a ^ ac_match[i]) & ac_mask[i]) == 24'd0) begin
            e.hit = 1'b1;
            e.idx = IW'(i);
            e.rom = 24'((int'(ac_off[i]) + int'(a & ac_amask[i])) % (1 << 24));
            e.sv  = ac_sv[i];
            e.wr  = ac_sv[i] | ac_wr[i];
            return e;
         end
      end
      return e;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NWIN; i++) begin
         sh_match[i] = '0; sh_mask[i] = '0; sh_off[i] = '0; sh_amask[i] = '0;
         sh_en[i] = 0; sh_sv[i] = 0; sh_wr[i] = 0;
         ac_match[i] = '0; ac_mask[i] = '0; ac_off[i] = '0; ac_amask[i] = '0;
         ac_en[i] = 0; ac_sv[i] = 0; ac_wr[i] = 0;
      end
      m_pend = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   // One clock edge: record the request, advance the model with the inputs
   // seen at this edge, then check the commit-pending status.
   task automatic step();
      logic copy;
      int   w;
      @(posedge CLK);
      if (RST) begin
         model_clear();
         exp_q.delete();
         cyc_q.delete();
      end else begin
         if (SNES_ADDR_VALID) begin
            exp_q.push_back(t_has_exp ? t_exp : model_calc(SNES_ADDR));
            cyc_q.push_back(cyc);
         end
         copy = m_pend && SNES_BUS_IDLE;
         if (cfg_we && !m_pend) begin
            w = int'(cfg_win);
            case (cfg_field)
               2'd0: sh_match[w] = cfg_data[23:0];
               2'd1: sh_mask[w]  = cfg_data[23:0];
               2'd2: sh_off[w]   = cfg_data[23:0];
               default: begin
                  sh_amask[w] = cfg_data[23:0];
                  sh_en[w]    = cfg_data[24];
                  sh_sv[w]    = cfg_data[25];
                  sh_wr[w]    = cfg_data[26];
               end
            endcase
         end
         if (copy) begin
            ac_match = sh_match; ac_mask = sh_mask; ac_off = sh_off; ac_amask = sh_amask;
            ac_en = sh_en; ac_sv = sh_sv; ac_wr = sh_wr;
         end
         if (!m_pend && cfg_commit) m_pend = 1'b1;
         else if (copy)             m_pend = 1'b0;
      end
      #1;
      checks++;
      if (cfg_busy !== m_pend || o_dbg_state !== m_pend) begin
         errors++;
         $display("FAIL busy cyc=%0d got busy=%b dbg=%b expected %b", cyc, cfg_busy, o_dbg_state, m_pend);
      end
   endtask

   task automatic cfg_write(int w, logic [1:0] f, logic [31:0] d);
      cfg_we = 1'b1; cfg_win = w[IW-1:0]; cfg_field = f; cfg_data = d;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic commit_idle();
      cfg_commit = 1'b1;
      step();
      cfg_commit = 1'b0;
      step();
   endtask

   task automatic req(logic [23:0] a);
      SNES_ADDR_VALID = 1'b1; SNES_ADDR = a;
      step();
      SNES_ADDR_VALID = 1'b0;
   endtask

   task automatic req_exp(logic [23:0] a, logic hit, int idx, logic [23:0] rom, logic sv, logic wr);
      t_has_exp = 1'b1;
      t_exp.hit = hit; t_exp.idx = idx[IW-1:0]; t_exp.rom = rom; t_exp.sv = sv; t_exp.wr = wr;
      req(a);
      t_has_exp = 1'b0;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge CLK) begin
      exp_t e, g;
      int   ic;
      g = {ROM_HIT, WIN_IDX, ROM_ADDR, IS_SAVERAM, IS_WRITABLE};
      if (exp_q.size() != 0 && cyc - cyc_q[0] > 2) begin
         checks++; errors++;
         $display("FAIL latency_timeout issued cyc=%0d now=%0d no out_valid", cyc_q[0], cyc);
         void'(exp_q.pop_front());
         void'(cyc_q.pop_front());
      end
      if (out_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out cyc=%0d got %h expected no output", cyc, g);
         end else begin
            e  = exp_q.pop_front();
            ic = cyc_q.pop_front();
            if (g !== e || cyc - ic != 2) begin
               errors++;
               $display("FAIL result cyc=%0d lat=%0d got hit=%b idx=%0d rom=%h sv=%b wr=%b expected hit=%b idx=%0d rom=%h sv=%b wr=%b lat=2",
                        cyc, cyc - ic, g.hit, g.idx, g.rom, g.sv, g.wr, e.hit, e.idx, e.rom, e.sv, e.wr);
            end
         end
      end else begin
         checks++;
         if (out_valid !== 1'b0 || g !== '0) begin
            errors++;
            $display("FAIL idle_outputs cyc=%0d got valid=%b %h expected all 0", cyc, out_valid, g);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      RST = 1'b1; SNES_ADDR = '0; SNES_ADDR_VALID = 1'b0; SNES_BUS_IDLE = 1'b1;
      cfg_we = 1'b0; cfg_commit = 1'b0; cfg_win = '0; cfg_field = '0; cfg_data = '0;
      t_has_exp = 1'b0; t_exp = '0;
      model_clear();
      repeat (3) step();
      RST = 1'b0;
      step();

      // window 0: upper half maps down
      cfg_write(0, 2'd0, 32'h0040_0000);
      cfg_write(0, 2'd1, 32'h0040_0000);
      cfg_write(0, 2'd2, 32'h0000_0000);
      cfg_write(0, 2'd3, 32'h013F_FFFF);
      req_exp(24'hC12345, 1'b0, 0, 24'h0, 1'b0, 1'b0);     // not yet committed
      commit_idle();
      req_exp(24'hC12345, 1'b1, 0, 24'h012345, 1'b0, 1'b0);

      // windows 1 and 2 share a match; lower index must win
      cfg_write(1, 2'd0, 32'h0030_6000);
      cfg_write(1, 2'd1, 32'h0040_E000);
      cfg_write(1, 2'd2, 32'h00E0_0000);
      cfg_write(1, 2'd3, 32'h0300_1FFF);
      cfg_write(2, 2'd0, 32'h0030_6000);
      cfg_write(2, 2'd1, 32'h0040_E000);
      cfg_write(2, 2'd2, 32'h0010_0000);
      cfg_write(2, 2'd3, 32'h0100_FFFF);
      commit_idle();
      req_exp(24'h306010, 1'b1, 1, 24'hE00010, 1'b1, 1'b1);

      // commit held off by a busy bus keeps the old mapping
      SNES_BUS_IDLE = 1'b0;
      cfg_write(0, 2'd2, 32'h0010_0000);
      cfg_commit = 1'b1; step(); cfg_commit = 1'b0;
      for (int i = 0; i < 10; i++) req_exp(24'hC12345, 1'b1, 0, 24'h012345, 1'b0, 1'b0);
      SNES_BUS_IDLE = 1'b1;
      req_exp(24'hC12345, 1'b1, 0, 24'h012345, 1'b0, 1'b0); // copy lands at this edge
      req_exp(24'hC12345, 1'b1, 0, 24'h112345, 1'b0, 1'b0);

      // wrap-around
      cfg_write(3, 2'd0, 32'h0);
      cfg_write(3, 2'd1, 32'h0);
      cfg_write(3, 2'd2, 32'h00FF_FFF0);
      cfg_write(3, 2'd3, 32'h0100_00FF);
      commit_idle();
      req_exp(24'h000020, 1'b1, 3, 24'h000010, 1'b0, 1'b0);

      // write during PEND is dropped
      SNES_BUS_IDLE = 1'b0;
      cfg_commit = 1'b1; step(); cfg_commit = 1'b0;
      cfg_write(3, 2'd2, 32'h0000_0100);
      SNES_BUS_IDLE = 1'b1;
      step();
      req_exp(24'h000020, 1'b1, 3, 24'h000010, 1'b0, 1'b0);

      // write and commit in the same cycle: the write is committed
      cfg_commit = 1'b1;
      cfg_write(3, 2'd2, 32'h0000_0200);
      cfg_commit = 1'b0;
      step();
      req_exp(24'h000020, 1'b1, 3, 24'h000220, 1'b0, 1'b0);

      // reset during PEND discards the commit and the table
      SNES_BUS_IDLE = 1'b0;
      cfg_commit = 1'b1; step(); cfg_commit = 1'b0;
      RST = 1'b1; step(); RST = 1'b0;
      SNES_BUS_IDLE = 1'b1;
      step();
      req_exp(24'hC12345, 1'b0, 0, 24'h0, 1'b0, 1'b0);

      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         int j;
         j = $urandom_range(0, NWIN - 1);
         SNES_BUS_IDLE = ($urandom_range(0, 1) == 1);
         cfg_we        = ($urandom_range(0, 3) == 0);
         cfg_win       = IW'($urandom_range(0, NWIN - 1));
         cfg_field     = 2'($urandom_range(0, 3));
         cfg_data      = $urandom;
         if (cfg_field == 2'd1) cfg_data[23:0] = cfg_data[23:0] & 24'hF0F000;
         cfg_commit    = ($urandom_range(0, 15) == 0);
         SNES_ADDR_VALID = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1)
            SNES_ADDR = (ac_match[j] & ac_mask[j]) | (24'($urandom) & ~ac_mask[j]);
         else
            SNES_ADDR = 24'($urandom);
         step();
      end
      SNES_ADDR_VALID = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;

      // drain the pipeline
      repeat (4) step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d outstanding expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got no finish expected finish by 2ms");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/addr_window_map.md
ADDR_WINDOW_MAP -- requirements
Module: addr_window_map

Interface
REQ-001 SHALL have parameter NWIN, default 8, number of programmable address windows (2..16).
REQ-002 SHALL have parameter IW, default 3, window index width, equal to clog2(NWIN).
REQ-003 SHALL have port CLK  in  1  system clock; single clock domain, all state on the rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port SNES_ADDR  in  24  SNES bus address to translate.
REQ-006 SHALL have port SNES_ADDR_VALID  in  1  translation request this cycle.
REQ-007 SHALL have port SNES_BUS_IDLE  in  1  no SNES access in flight; table update permitted.
REQ-008 SHALL have port cfg_we  in  1  shadow register write strobe.
REQ-009 SHALL have port cfg_win  in  IW  window selected for the write.
REQ-010 SHALL have port cfg_field  in  2  field select: 0=match, 1=mask, 2=offset, 3=amask+flags.
REQ-011 SHALL have port cfg_data  in  32  write data: [23:0] value; field 3 also carries [24] enable, [25] saveram, [26] writable.
REQ-012 SHALL have port cfg_commit  in  1  request atomic copy of shadow table to active table.
REQ-013 SHALL have port cfg_busy  out  1  commit pending.
REQ-014 SHALL have port ROM_ADDR  out  24  translated address.
REQ-015 SHALL have port ROM_HIT, IS_SAVERAM, IS_WRITABLE, out_valid  out  1 each  result qualifiers.
REQ-016 SHALL have port WIN_IDX  out  IW  index of the winning window.

Function
REQ-017 Each window SHALL hold shadow and active copies of: match[23:0], mask[23:0], offset[23:0], amask[23:0], enable, saveram, writable.
REQ-018 cfg_we with cfg_busy=0 SHALL write the selected shadow field at the clock edge; cfg_we with cfg_busy=1 SHALL be ignored.
REQ-019 Commit FSM: IDLE --cfg_commit--> PEND; in PEND, SNES_BUS_IDLE=1 SHALL copy all shadows to active at that edge and return to IDLE; cfg_busy=1 exactly in PEND.
REQ-020 A cfg_we and cfg_commit in the same cycle SHALL both take effect, and the write SHALL be included in the commit; cfg_commit while in PEND SHALL have no effect.
REQ-021 Window i SHALL hit when active enable=1 and ((SNES_ADDR xor match) and mask) equals 0.
REQ-022 On multiple hits, the lowest window index SHALL win.
REQ-023 Stage 1 SHALL register the SNES address, the winner index, the hit flag, and the winner's offset, amask and flags; stage 2 SHALL register ROM_ADDR = (offset + (SNES_ADDR and amask)) mod 2^24.
REQ-024 Latency SHALL be exactly 2 cycles, from a request with SNES_ADDR_VALID=1 to out_valid=1, with a throughput of one request per cycle.
REQ-025 A translation SHALL use the active table as sampled in its stage-1 cycle; a commit landing mid-pipeline SHALL NOT alter an in-flight result.
REQ-026 With no hit, or with out_valid=0, ROM_HIT, IS_SAVERAM, IS_WRITABLE, ROM_ADDR and WIN_IDX SHALL be 0.
REQ-027 IS_WRITABLE SHALL equal winner.writable or winner.saveram; IS_SAVERAM SHALL equal winner.saveram.

Reset
REQ-028 RST SHALL clear all shadow and active fields to 0 (all windows disabled), force the FSM to IDLE, and clear both pipeline stages.
REQ-029 After RST, all outputs SHALL be 0; an RST during PEND SHALL discard the pending commit.

Structure
REQ-030 The shared package addr_window_pkg SHALL hold the cfg_field encodings, the flag bit positions (24/25/26) and the FSM state type.
REQ-031 A sub-module addr_window_entry (shadow/active registers plus hit comparator) SHALL be instantiated NWIN times; priority selection, pipeline and FSM SHALL live in addr_window_map.

Verification
REQ-032 Program win0: match=0x400000, mask=0x400000, offset=0, amask=0x3FFFFF, enable; commit with idle=1; request 0xC12345 -> 2 cycles later ROM_HIT=1, ROM_ADDR=0x012345, WIN_IDX=0.
REQ-033 Add win1 saveram: match=0x306000, mask=0x40E000, offset=0xE00000, amask=0x001FFF; also win2 with an identical match; request 0x306010 -> WIN_IDX=1, ROM_ADDR=0xE00010, IS_SAVERAM=1, IS_WRITABLE=1.
REQ-034 Commit with SNES_BUS_IDLE=0 held for 10 cycles -> cfg_busy=1 throughout and the old mapping is still used; idle=1 -> new mapping active from the next edge, and cfg_busy falls.
REQ-035 Program offset=0xFFFFF0, amask=0x0000FF, match/mask=0; request 0x000020 -> ROM_ADDR=0x000010 (wrap-around).
REQ-036 Issue cfg_we during PEND -> the shadow value is unchanged after the commit; assert RST during PEND -> cfg_busy=0, a request to 0xC12345 gives ROM_HIT=0 and ROM_ADDR=0.
